// File: rtl/sat_narrow_pkg.sv
// Fixed-point helpers shared by the narrowing stage: format widths, range limits
// and the rounding-mode encoding.
package fixpt_pkg;

    typedef enum logic {
        RND_HALF_UP = 1'b0,
        RND_TRUNC   = 1'b1
    } rnd_mode_e;

    function automatic int dw_f(input int s, input int i, input int f);
        return s + i + f;
    endfunction

    function automatic int in_w_f(input int s, input int i, input int f,
                                  input int ei, input int ef);
        return s + i + f + ei + ef;
    endfunction

    function automatic logic [63:0] fx_max(input int dw);
        return (64'd1 << (dw - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] fx_min(input int dw);
        return 64'd1 << (dw - 1);
    endfunction

endpackage

// File: rtl/sat_narrow_pipe_reg.sv
// Valid/ready register slice; holds its contents while the consumer stalls.
module pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) out_data <= in_data;
        end
    end

endmodule

// File: rtl/sat_narrow.sv
// Narrows a widened signed fixed-point sum back to the base format:
// round off surplus fraction (stage 1), saturate surplus integer range (stage 2).
module sat_narrow
    import fixpt_pkg::*;
#(
    parameter int        SIGN_BIT = 1,
    parameter int        INT_BIT  = 7,
    parameter int        FLT_BIT  = 0,
    parameter int        EXT_INT  = 1,
    parameter int        EXT_FLT  = 0,
    parameter int        CNT_W    = 16,
    parameter rnd_mode_e RND_MODE = RND_HALF_UP,
    localparam int       DW       = dw_f(SIGN_BIT, INT_BIT, FLT_BIT),
    localparam int       IW       = in_w_f(SIGN_BIT, INT_BIT, FLT_BIT, EXT_INT, EXT_FLT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IW-1:0]    din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [DW-1:0]    dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             sat_flag,
    output logic [CNT_W-1:0] sat_cnt,
    input  logic             clr
);

    // One guard bit above DW+EXT_INT keeps the rounding carry.
    localparam int          RW    = DW + EXT_INT + 1;
    localparam logic [63:0] MAX64 = fx_max(DW);
    localparam logic [63:0] MIN64 = fx_min(DW);
    localparam logic [DW-1:0] MAXV = MAX64[DW-1:0];
    localparam logic [DW-1:0] MINV = MIN64[DW-1:0];
    localparam logic [IW:0] BIAS =
        (EXT_FLT > 0 && RND_MODE == RND_HALF_UP)
            ? ((IW+1)'(1) << ((EXT_FLT > 0) ? EXT_FLT - 1 : 0)) : '0;

    logic [IW:0]     din_x;
    logic [RW-1:0]   rnd;
    logic            s1_valid, s2_ready;
    logic [RW-1:0]   s1_data;
    logic [EXT_INT:0] upper;
    logic            sat;
    logic [DW-1:0]   narrowed;
    logic            sat_ev;

    assign din_x = {din[IW-1], din};
    assign rnd   = RW'((din_x + BIAS) >> EXT_FLT);

    pipe_reg #(.W(RW)) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (din_valid),
        .in_ready  (din_ready),
        .in_data   (rnd),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_data)
    );

    // In range only when the dropped bits all copy the new sign bit.
    assign upper    = s1_data[RW-1:DW-1];
    assign sat      = !((&upper) || !(|upper));
    assign narrowed = sat ? (s1_data[RW-1] ? MINV : MAXV) : s1_data[DW-1:0];
    assign sat_ev   = s1_valid && s2_ready && sat;

    pipe_reg #(.W(DW)) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (narrowed),
        .out_valid (dout_valid),
        .out_ready (dout_ready),
        .out_data  (dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
            sat_cnt  <= '0;
        end else if (clr) begin
            sat_flag <= 1'b0;
            sat_cnt  <= '0;
        end else if (sat_ev) begin
            sat_flag <= 1'b1;
            if (sat_cnt != '1) sat_cnt <= sat_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sat_narrow.sv
// Bench for sat_narrow: default format, a 2-bit rounding variant and a 4-bit counter variant.
module tb_sat_narrow;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        din_valid, dout_ready, clr;
    logic [8:0]  din_a;
    logic [10:0] din_b;
    logic        din_ready_a, din_ready_b, din_ready_c;
    logic [7:0]  dout_a, dout_b, dout_c;
    logic        dout_valid_a, dout_valid_b, dout_valid_c;
    logic        sat_flag_a, sat_flag_b, sat_flag_c;
    logic [15:0] sat_cnt_a, sat_cnt_b;
    logic [3:0]  sat_cnt_c;

    always #5 clk = ~clk;

    sat_narrow u_a (
        .clk(clk), .rst_n(rst_n), .din(din_a), .din_valid(din_valid), .din_ready(din_ready_a),
        .dout(dout_a), .dout_valid(dout_valid_a), .dout_ready(dout_ready),
        .sat_flag(sat_flag_a), .sat_cnt(sat_cnt_a), .clr(clr));

    sat_narrow #(.EXT_FLT(2)) u_b (
        .clk(clk), .rst_n(rst_n), .din(din_b), .din_valid(din_valid), .din_ready(din_ready_b),
        .dout(dout_b), .dout_valid(dout_valid_b), .dout_ready(dout_ready),
        .sat_flag(sat_flag_b), .sat_cnt(sat_cnt_b), .clr(clr));

    sat_narrow #(.CNT_W(4)) u_c (
        .clk(clk), .rst_n(rst_n), .din(din_a), .din_valid(din_valid), .din_ready(din_ready_c),
        .dout(dout_c), .dout_valid(dout_valid_c), .dout_ready(dout_ready),
        .sat_flag(sat_flag_c), .sat_cnt(sat_cnt_c), .clr(clr));

    int errors = 0;
    int checks = 0;
    int qa[$], qb[$], qcyc[$];
    int mdl_sat_a = 0, mdl_sat_b = 0;
    int cyc = 0;
    bit lat_mode = 0, rnd_bp = 0;
    bit prev_stall = 0;
    logic [7:0] prev_dout;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: scale by 2^-ef with round-half-up (floor of v/2^ef + 1/2), then clamp to int8.
    function automatic int mdl(input int v, input int ef, output bit s);
        int r;
        if (ef > 0) r = (v + (1 << (ef - 1))) >>> ef;
        else        r = v;
        s = (r > 127) || (r < -128);
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    always @(negedge clk) begin
        int  ea, eb;
        bit  sa, sb;
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            cyc++;
            if (din_valid && din_ready_a) begin
                ea = mdl(int'($signed(din_a)), 0, sa);
                eb = mdl(int'($signed(din_b)), 2, sb);
                qa.push_back(ea);
                qb.push_back(eb);
                qcyc.push_back(cyc);
                if (sa) mdl_sat_a++;
                if (sb) mdl_sat_b++;
            end
            if (prev_stall) begin
                chk("stall_valid", dout_valid_a, 1);
                chk("stall_dout", dout_a, prev_dout);
            end
            if (dout_valid_a && dout_ready) begin
                chk("pop_nonempty", qa.size() > 0, 1);
                if (qa.size() > 0) begin
                    chk("a_dout", dout_a, qa[0] & 255);
                    chk("c_dout", dout_c, qa[0] & 255);
                    if (lat_mode) chk("latency", cyc - qcyc[0], 2);
                    void'(qa.pop_front());
                    void'(qcyc.pop_front());
                end
            end
            if (dout_valid_b && dout_ready) begin
                chk("b_nonempty", qb.size() > 0, 1);
                if (qb.size() > 0) chk("b_dout", dout_b, qb.pop_front() & 255);
            end
            prev_stall = dout_valid_a && !dout_ready;
            prev_dout  = dout_a;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input int a, input int b);
        bit done = 0;
        din_a     = a[8:0];
        din_b     = b[10:0];
        din_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            if (rnd_bp) dout_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (din_ready_a) done = 1;
            @(posedge clk); #1;
        end
        din_valid = 1'b0;
        chk("send_timeout", done, 1);
    endtask

    task automatic drain();
        rnd_bp     = 0;
        dout_ready = 1'b1;
        for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) tick();
        tick();
        chk("drain", qa.size() + qb.size(), 0);
    endtask

    task automatic chk_cnt();
        chk("a_cnt", sat_cnt_a, mdl_sat_a);
        chk("a_flag", sat_flag_a, mdl_sat_a > 0);
        chk("b_cnt", sat_cnt_b, mdl_sat_b);
        chk("b_flag", sat_flag_b, mdl_sat_b > 0);
        chk("c_cnt", sat_cnt_c, (mdl_sat_a > 15) ? 15 : mdl_sat_a);
        chk("c_flag", sat_flag_c, mdl_sat_a > 0);
    endtask

    initial begin
        rst_n = 1'b0; din_valid = 1'b0; dout_ready = 1'b1; clr = 1'b0;
        din_a = '0; din_b = '0;
        tick();
        chk("rst_dout_valid", dout_valid_a, 0);
        chk("rst_dout", dout_a, 0);
        chk("rst_flag", sat_flag_a, 0);
        chk("rst_cnt", sat_cnt_a, 0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("rst_din_ready", din_ready_a, 1);
        tick();

        // Directed stream through the default format, 2-cycle latency.
        lat_mode = 1;
        begin
            int va[5] = '{'h07F, 'h080, 'h180, 'h17F, 'h1FF};
            for (int i = 0; i < 5; i++) send(va[i], int'($signed(va[i][8:0])) * 4);
        end
        drain();
        chk("t1_cnt_a", sat_cnt_a, 2);
        chk("t1_flag_a", sat_flag_a, 1);
        chk_cnt();

        // Rounding variant: +3.5, +3.25, -2.5, -2.75, +127.5 in Q.2.
        begin
            int vb[5] = '{14, 13, -10, -11, 510};
            for (int i = 0; i < 5; i++) send($urandom_range(0, 511), vb[i]);
        end
        drain();
        chk_cnt();
        lat_mode = 0;

        // Backpressure: pipeline fills with two values, then stalls.
        dout_ready = 1'b0;
        send(5, 20);
        send(-7, -30);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_din_ready", din_ready_a, 0);
        end
        tick();
        dout_ready = 1'b1;
        for (int i = 0; i < 8; i++) send($urandom_range(0, 511), $urandom_range(0, 2047));
        drain();
        chk_cnt();

        // Random traffic under random backpressure.
        rnd_bp = 1;
        for (int i = 0; i < 40; i++) send($urandom_range(0, 511), $urandom_range(0, 2047));
        drain();
        chk_cnt();

        // Clear, then drive the 4-bit counter past its ceiling.
        clr = 1'b1; tick(); clr = 1'b0;
        mdl_sat_a = 0; mdl_sat_b = 0;
        chk_cnt();
        for (int i = 0; i < 20; i++) send(200, 800);
        drain();
        chk("c_cnt_sat", sat_cnt_c, 4'hF);
        chk_cnt();
        send(-200, -800);
        drain();
        chk_cnt();

        // Clear lands on the same edge that loads a saturated result into stage 2.
        send(-200, -800);
        clr = 1'b1; tick(); clr = 1'b0;
        drain();
        mdl_sat_a = 0; mdl_sat_b = 0;
        chk("clr_cnt_a", sat_cnt_a, 0);
        chk("clr_flag_a", sat_flag_a, 0);
        chk_cnt();

        // Asynchronous reset with two values in flight.
        dout_ready = 1'b0;
        send(100, 400);
        send(-100, -400);
        #2 rst_n = 1'b0;
        #1 chk("arst_dout_valid", dout_valid_a, 0);
        chk("arst_b_valid", dout_valid_b, 0);
        qa.delete(); qb.delete(); qcyc.delete();
        mdl_sat_a = 0; mdl_sat_b = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("arst_din_ready", din_ready_a, 1);
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("arst_no_out", dout_valid_a, 0);
        end
        tick();
        chk_cnt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sat_narrow.md
Name: sat_narrow

Overview:
- Narrowing stage that pairs with the sign-extending adder.
- Takes a widened signed fixed-point sum (integer growth bits plus extra fractional bits) and returns it to the SIGN_BIT+INT_BIT+FLT_BIT format.
- Rounds off the surplus fraction, then saturates the surplus integer range.
- Two-stage pipeline with valid/ready handshake; sits between an adder/MAC tree and any storage or next adder that expects the base format.

Parameters:
- SIGN_BIT, 1, sign bits of the output format.
- INT_BIT, 7, integer bits of the output format.
- FLT_BIT, 0, fractional bits of the output format.
- EXT_INT, 1, extra integer (growth) bits on the input; 1 matches one adder level.
- EXT_FLT, 0, extra fractional bits on the input that are rounded off (0 = no rounding).
- CNT_W, 16, width of the saturation event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  DW+EXT_INT+EXT_FLT  signed two's-complement wide value, where DW = SIGN_BIT+INT_BIT+FLT_BIT.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  block accepts din this cycle.
- dout  output  DW  narrowed, rounded, saturated result.
- dout_valid  output  1  dout is valid.
- dout_ready  input  1  downstream accepts dout.
- sat_flag  output  1  sticky: set by any saturation event.
- sat_cnt  output  CNT_W  number of saturated results, stops at all-ones.
- clr  input  1  synchronous clear of sat_flag and sat_cnt.

Behaviour:
- Clock and reset:
  - Single clock clk.
  - Reset rst_n is asynchronous, active-low.
  - Reset values: all stage valids 0, dout 0, dout_valid 0, sat_flag 0, sat_cnt 0.
  - din_ready is 1 in the first cycle after reset.
- Handshake:
  - A transfer occurs when valid and ready are both high on a rising edge.
  - din_ready = !s1_valid || s1_advance.
  - s1_advance = !s2_valid || dout_ready.
  - Full throughput: one result per cycle when dout_ready is held high.
  - Under backpressure no data is lost or duplicated.
  - dout and dout_valid are held stable while dout_valid=1 and dout_ready=0.
- Latency: accepted din appears on dout exactly 2 cycles later when there is no backpressure.
- Stage 1 (round):
  - If EXT_FLT>0: add 2^(EXT_FLT-1) to din (round half up, toward +inf), then drop the low EXT_FLT bits.
  - The intermediate is one bit wider than DW+EXT_INT, so the rounding carry is not lost.
  - If EXT_FLT=0: pass through.
- Stage 2 (saturate):
  - MAX = 0 followed by DW-1 ones; MIN = 1 followed by DW-1 zeros.
  - Value > MAX -> MAX; value < MIN -> MIN; otherwise the low DW bits.
  - Saturation is detected by checking that the discarded upper bits and the new sign bit are not all equal.
- Counters:
  - A saturation event is counted only when its result is loaded into stage 2.
  - Each event sets sat_flag and increments sat_cnt; sat_cnt holds at 2^CNT_W-1.
  - clr has priority over a same-cycle event: both registers are cleared, and that event is not counted.
- Boundary cases:
  - Rounding overflow (e.g. max positive with a .5 fraction) saturates to MAX.
  - Exactly MAX or MIN passes through without a saturation event.
  - Reset mid-stream discards in-flight data.
  - A simultaneous accept and output pop while full still keeps full throughput.

Decomposition:
- Shared package fixpt_pkg holds:
  - localparam functions for DW and the input width;
  - fx_max/fx_min constant functions;
  - a round-mode enum (only RND_HALF_UP is implemented; RND_TRUNC is reserved).
- One natural sub-module, pipe_reg: a valid/ready register slice with a data width parameter, instantiated twice.
- Rounding and saturation logic stays inline.

Test Plan:
- Defaults (9b in, 8b out), stream din = 9'h07F, 9'h080, 9'h180, 9'h17F, 9'h1FF with dout_ready=1:
  - dout = 8'h7F, 8'h7F, 8'h80, 8'h80, 8'hFF at 2-cycle latency.
  - sat_cnt = 2, sat_flag = 1.
- EXT_FLT=2, FLT_BIT=0, din = +3.5, +3.25, -2.5, -2.75:
  - dout = 4, 3, -2, -3.
  - din = +127.5 -> dout = 127 with sat_cnt incremented.
- Backpressure: stream 10 values, hold dout_ready=0 for 5 cycles mid-stream:
  - din_ready drops after 2 values are queued;
  - the output sequence is complete and in order, with no duplicates;
  - dout stays stable while stalled.
- Counter boundary, CNT_W=4: 20 saturating inputs -> sat_cnt = 4'hF and holds.
- clr in the same cycle as a saturation event: sat_cnt = 0 and sat_flag = 0 afterwards.
- Assert rst_n low asynchronously while 2 values are in flight:
  - dout_valid falls immediately, with no output after release;
  - din_ready = 1 on the first cycle after release.
